// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle controller: decodes ROM/SRAM/UART/IACK and drives chip selects, SRAM strobes, DTACKn/VPAn.
// Define BUS_TIMEOUT_EN to raise BERRn on unmapped cycles after TIMEOUT_CYCLES wait edges.
module m68k_bus_ctrl #(
  parameter int unsigned ROM_WS         = 2,
  parameter int unsigned SRAM_WS        = 0,
  parameter int unsigned IO_WS          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK68000,
  input  logic        RESETn,
  input  logic [22:0] addr,
  input  logic        ASn,
  input  logic        R_Wn,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic [2:0]  FC,
  output logic        DTACKn,
  output logic        VPAn,
  output logic        BERRn,
  output logic        ROM_CEn,
  output logic        SRAM_CEn,
  output logic        SRAM_OEn,
  output logic        SRAM_WEn,
  output logic        SRAM_UBn,
  output logic        SRAM_LBn,
  output logic        UART_CSn
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_BERR = 2'd3;

  localparam logic [2:0] RG_ROM   = 3'd0;
  localparam logic [2:0] RG_SRAM  = 3'd1;
  localparam logic [2:0] RG_UART  = 3'd2;
  localparam logic [2:0] RG_IACK  = 3'd3;
  localparam logic [2:0] RG_UNMAP = 3'd4;

  localparam logic [7:0] ROM_WS_L  = 8'(ROM_WS);
  localparam logic [7:0] SRAM_WS_L = 8'(SRAM_WS);
  localparam logic [7:0] IO_WS_L   = 8'(IO_WS);

  logic [1:0] state;
  logic [2:0] region;
  logic       rw_lat;
  logic [7:0] cnt;
  logic       dtack_n;
  logic       vpa_n;
  logic       rom_ce_n;
  logic       sram_sel;
  logic       uart_cs_n;

  logic [2:0] region_dec;
  logic [7:0] ws_dec;
  logic       unused_addr_bits;

  // addr is A[23:1]; the byte-address ranges only need the top bits, so A[3:1] never matter.
  assign unused_addr_bits = ^addr[2:0];

  always_comb begin
    region_dec = RG_UNMAP;
    ws_dec     = 8'd0;
    if (FC == 3'b111 && (&addr[22:3])) begin
      region_dec = RG_IACK;
    end else if (addr[22:19] == 4'h0) begin
      region_dec = RG_ROM;
      ws_dec     = ROM_WS_L;
    end else if (addr[22:19] == 4'h1) begin
      region_dec = RG_SRAM;
      ws_dec     = SRAM_WS_L;
    end else if (addr[22:15] == 8'hF0) begin
      region_dec = RG_UART;
      ws_dec     = IO_WS_L;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
  logic       berr_n;
  assign BERRn = berr_n;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign BERRn = 1'b1;
`endif

  // Selects and the acknowledge are registered; leaving a cycle (ASn high or reset) clears them on that edge.
  always_ff @(posedge CLK68000 or negedge RESETn) begin
    if (!RESETn) begin
      state     <= ST_IDLE;
      region    <= RG_UNMAP;
      rw_lat    <= 1'b1;
      cnt       <= 8'd0;
      dtack_n   <= 1'b1;
      vpa_n     <= 1'b1;
      rom_ce_n  <= 1'b1;
      sram_sel  <= 1'b0;
      uart_cs_n <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      to_cnt    <= 8'd0;
      berr_n    <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!ASn) begin
            state  <= ST_WAIT;
            region <= region_dec;
            rw_lat <= R_Wn;
            cnt    <= ws_dec;
`ifdef BUS_TIMEOUT_EN
            to_cnt <= 8'd0;
`endif
          end
        end
        ST_WAIT: begin
          if (ASn) begin
            state     <= ST_IDLE;
            rom_ce_n  <= 1'b1;
            sram_sel  <= 1'b0;
            uart_cs_n <= 1'b1;
          end else begin
            rom_ce_n  <= (region != RG_ROM);
            sram_sel  <= (region == RG_SRAM);
            uart_cs_n <= (region != RG_UART);
            if (cnt == 8'd0 && region != RG_UNMAP) begin
              state <= ST_ACK;
              if (region == RG_IACK) vpa_n <= 1'b0;
              else                   dtack_n <= 1'b0;
            end else if (cnt != 8'd0) begin
              cnt <= cnt - 8'd1;
            end
`ifdef BUS_TIMEOUT_EN
            // Only unmapped cycles can stall forever; mapped ones acknowledge within 255 edges.
            if (region == RG_UNMAP) begin
              if (to_cnt == TIMEOUT_LAST) begin
                state  <= ST_BERR;
                berr_n <= 1'b0;
              end else if (to_cnt != 8'hFF) begin
                to_cnt <= to_cnt + 8'd1;
              end
            end
`endif
          end
        end
        ST_ACK: begin
          if (ASn) begin
            state     <= ST_IDLE;
            dtack_n   <= 1'b1;
            vpa_n     <= 1'b1;
            rom_ce_n  <= 1'b1;
            sram_sel  <= 1'b0;
            uart_cs_n <= 1'b1;
          end
        end
        ST_BERR: begin
          if (ASn) begin
            state <= ST_IDLE;
`ifdef BUS_TIMEOUT_EN
            berr_n <= 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign DTACKn   = dtack_n;
  assign VPAn     = vpa_n;
  assign ROM_CEn  = rom_ce_n;
  assign SRAM_CEn = ~sram_sel;
  assign UART_CSn = uart_cs_n;

  // Byte lanes and write enable follow the live data strobes, gated by the registered select.
  assign SRAM_OEn = ~(sram_sel & rw_lat);
  assign SRAM_WEn = ~(sram_sel & ~rw_lat & (~UDSn | ~LDSn));
  assign SRAM_UBn = UDSn | ~sram_sel;
  assign SRAM_LBn = LDSn | ~sram_sel;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Self-checking bench for m68k_bus_ctrl: directed bus cycles plus random cycles checked against a timeline model.
module tb_m68k_bus_ctrl;

  localparam int ROM_WS  = 2;
  localparam int SRAM_WS = 0;
  localparam int IO_WS   = 4;
  localparam int TMO     = 64;

  logic        clk;
  logic        rst_n;
  logic [22:0] addr;
  logic        as_n;
  logic        r_w_n;
  logic        uds_n;
  logic        lds_n;
  logic [2:0]  fc;
  logic        dtack_n, vpa_n, berr_n, rom_ce_n, sram_ce_n;
  logic        sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, uart_cs_n;

  int tests_run    = 0;
  int tests_failed = 0;

  m68k_bus_ctrl #(
    .ROM_WS(ROM_WS), .SRAM_WS(SRAM_WS), .IO_WS(IO_WS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK68000(clk), .RESETn(rst_n), .addr(addr), .ASn(as_n), .R_Wn(r_w_n),
    .UDSn(uds_n), .LDSn(lds_n), .FC(fc), .DTACKn(dtack_n), .VPAn(vpa_n),
    .BERRn(berr_n), .ROM_CEn(rom_ce_n), .SRAM_CEn(sram_ce_n), .SRAM_OEn(sram_oe_n),
    .SRAM_WEn(sram_we_n), .SRAM_UBn(sram_ub_n), .SRAM_LBn(sram_lb_n), .UART_CSn(uart_cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] observed();
    return {dtack_n, vpa_n, berr_n, rom_ce_n, sram_ce_n,
            sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, uart_cs_n};
  endfunction

  task automatic checkOutput(input string tag, input logic [9:0] got, input logic [9:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // 0 ROM, 1 SRAM, 2 UART, 3 IACK, 4 unmapped, from the byte address map
  function automatic int classify(input logic [22:0] a, input logic [2:0] f);
    int unsigned b;
    b = int'(a) * 2;
    if (f == 3'b111 && b >= 32'hFFFFF0) return 3;
    if (b < 32'h100000) return 0;
    if (b < 32'h200000) return 1;
    if (b >= 32'hF00000 && b < 32'hF10000) return 2;
    return 4;
  endfunction

  function automatic int wait_states(input int rg);
    case (rg)
      0: return ROM_WS;
      1: return SRAM_WS;
      2: return IO_WS;
      default: return 0;
    endcase
  endfunction

  // Expected outputs after edge j of a cycle whose ASn is sampled low on edges 0..len-1.
  function automatic logic [9:0] model(input int rg, input logic rw, input logic uds,
                                       input logic lds, input int j, input int len);
    bit act, dt, vp, be, rom, sram, uart;
    act  = (j >= 1) && (j < len);
    dt   = act && (rg <= 2) && (j >= 1 + wait_states(rg));
    vp   = act && (rg == 3);
    be   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    be   = act && (rg == 4) && (j >= TMO);
`endif
    rom  = act && (rg == 0);
    sram = act && (rg == 1);
    uart = act && (rg == 2);
    return {~dt, ~vp, ~be, ~rom, ~sram, ~(sram && rw), ~(sram && !rw && (!uds || !lds)),
            uds | ~sram, lds | ~sram, ~uart};
  endfunction

  task automatic applyStimulus(input string name, input logic [22:0] a, input logic rw,
                               input logic uds, input logic lds, input logic [2:0] f,
                               input int len, input int gap);
    int   rg, falls, exp_falls;
    logic prev;
    rg    = classify(a, f);
    falls = 0;
    prev  = 1'b1;
    for (int j = 0; j <= len; j++) begin
      @(negedge clk);
      if (j == 0) begin
        addr = a; fc = f; r_w_n = rw; uds_n = uds; lds_n = lds; as_n = 1'b0;
      end else if (j < len) begin
        addr = 23'($urandom);
        fc   = 3'($urandom);
      end else begin
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s_e%0d", name, j), observed(), model(rg, rw, uds, lds, j, len));
      if (prev && !dtack_n) falls++;
      prev = dtack_n;
    end
    exp_falls = (rg <= 2 && len > 1 + wait_states(rg)) ? 1 : 0;
    checkOutput($sformatf("%s_acks", name), 10'(falls), 10'(exp_falls));
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s_gap%0d", name, g), observed(), 10'h3FF);
    end
  endtask

  initial begin
    logic [22:0] a;
    logic [2:0]  f;
    int          pick, dt_low;

    rst_n = 1'b0; as_n = 1'b1; r_w_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    fc = 3'b101; addr = 23'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", observed(), 10'h3FF);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("rom_read", 23'h000002, 1'b1, 1'b0, 1'b0, 3'b110, 5, 1);
    applyStimulus("sram_wr_ub", 23'h080008, 1'b0, 1'b0, 1'b1, 3'b101, 3, 1);
    applyStimulus("sram_rd", 23'h0FFFFF, 1'b1, 1'b0, 1'b0, 3'b101, 2, 1);
    applyStimulus("iack", 23'h7FFFF8, 1'b1, 1'b1, 1'b0, 3'b111, 3, 1);
    applyStimulus("uart_abort", 23'h780010, 1'b1, 1'b1, 1'b0, 3'b101, 2, 2);
    applyStimulus("rom_b2b", 23'h000100, 1'b1, 1'b0, 1'b0, 3'b110, 12, 1);
    applyStimulus("rom_last", 23'h07FFFF, 1'b1, 1'b0, 1'b0, 3'b110, 4, 0);
    applyStimulus("uart_full", 23'h787FFF, 1'b0, 1'b1, 1'b0, 3'b101, 7, 1);
`ifdef BUS_TIMEOUT_EN
    applyStimulus("unmapped", 23'h400000, 1'b1, 1'b0, 1'b0, 3'b101, 70, 1);
`else
    applyStimulus("unmapped", 23'h400000, 1'b1, 1'b0, 1'b0, 3'b101, 300, 1);
`endif

    // Reset asserted while a UART cycle is still waiting: everything must drop at once.
    dt_low = 0;
    @(negedge clk);
    addr = 23'h780004; fc = 3'b101; r_w_n = 1'b1; as_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_mid_sel", observed(), 10'h3FE);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_mid_async", observed(), 10'h3FF);
    @(negedge clk);
    as_n  = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (!dtack_n) dt_low++;
    end
    checkOutput("rst_mid_noack", 10'(dt_low), 10'd0);

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 4);
      f    = 3'($urandom_range(0, 6));
      case (pick)
        0: a = 23'($urandom_range(0, 32'h7FFFF));
        1: a = 23'(32'h80000 + $urandom_range(0, 32'h7FFFF));
        2: a = 23'(32'h780000 + $urandom_range(0, 32'h7FFF));
        3: begin a = 23'(32'h7FFFF8 + $urandom_range(0, 7)); f = 3'b111; end
        default: a = 23'(32'h100000 + $urandom_range(0, 32'h677FFF));
      endcase
      applyStimulus($sformatf("rnd%0d", n), a, 1'($urandom), 1'($urandom), 1'($urandom),
                    f, $urandom_range(1, 12), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/m68k_bus_ctrl.md
Name: m68k_bus_ctrl

Overview:
- Bus-cycle controller between the 68000 bus (ASn/R_Wn/UDSn/LDSn/FC/addr) and the board's memory and IO devices.
- Decodes each cycle into ROM, SRAM, UART or interrupt-acknowledge; drives chip selects and SRAM strobes.
- Terminates the cycle with DTACKn after a per-region wait-state count, or with VPAn for autovectored interrupt acknowledge.
- Supplies the DTACKn/VPAn/SRAM_OEn that the m68k top level currently hard-wires; fully synchronous to CLK68000.

Parameters:
- ROM_WS, 2, wait states for ROM region (0..255)
- SRAM_WS, 0, wait states for SRAM region (0..255)
- IO_WS, 4, wait states for UART region (0..255)
- TIMEOUT_CYCLES, 64, cycles before bus error on an unacknowledged cycle (1..255, used only with macro)

Ports:
- CLK68000  in  1  CPU bus clock; all state on rising edge
- RESETn  in  1  asynchronous active-low reset
- addr  in  23  A[23:1]
- ASn  in  1  address strobe, active low; synchronous to CLK68000, no synchronizer
- R_Wn  in  1  1=read, 0=write
- UDSn  in  1  upper data strobe, active low
- LDSn  in  1  lower data strobe, active low
- FC  in  3  function code
- DTACKn  out  1  data transfer acknowledge, active low
- VPAn  out  1  valid peripheral address (autovector), active low
- BERRn  out  1  bus error, active low
- ROM_CEn  out  1  ROM chip enable
- SRAM_CEn  out  1  SRAM chip enable
- SRAM_OEn  out  1  SRAM output enable (reads only)
- SRAM_WEn  out  1  SRAM write enable (writes only)
- SRAM_UBn  out  1  SRAM upper byte lane, follows UDSn
- SRAM_LBn  out  1  SRAM lower byte lane, follows LDSn
- UART_CSn  out  1  UART register select

Behaviour:
- Reset (RESETn=0, async): state IDLE, counter 0; every output 1 (inactive). Reset mid-cycle drops all strobes immediately; no acknowledge is ever issued for that cycle.
- Decode on byte address {addr,1'b0}, priority order:
  - IACK: FC=3'b111 and addr[23:4] all ones
  - ROM: 0x000000-0x0FFFFF
  - SRAM: 0x100000-0x1FFFFF
  - UART: 0xF00000-0xF0FFFF
  - everything else UNMAPPED
- Region is latched at cycle start and held until IDLE; addr changes mid-cycle are ignored.
- States: IDLE, WAIT, ACK, BERR.
- IDLE: at edge k sampling ASn=0 -> latch region and R_Wn, load counter with the region's WS (IACK loads 0), go to WAIT.
- WAIT: counter decrements each edge. When counter=0 and region is mapped or IACK -> ACK. UNMAPPED stays in WAIT (see Optional Feature).
- Chip select for the latched region asserts from edge k+1.
- DTACKn (or VPAn for IACK) falls at edge k+1+WS and is registered. WS=0 gives one cycle of latency.
- ACK: hold DTACKn/VPAn and selects low until ASn sampled 1, then IDLE. All outputs return to 1 on that same edge.
- Abort: ASn sampled 1 in WAIT -> IDLE and outputs inactive on that edge, no acknowledge.
- Back-to-back: IDLE needs ASn=1 for at least one edge after ACK/BERR before accepting a new cycle. ASn low throughout is never double-acknowledged.
- SRAM strobes:
  - SRAM_OEn=0 while SRAM selected and latched R_Wn=1.
  - SRAM_WEn=0 while SRAM selected, latched R_Wn=0 and (UDSn=0 or LDSn=0).
  - SRAM_UBn = UDSn or not-selected; SRAM_LBn = LDSn or not-selected. These are combinational from the live strobes, gated by the registered select.
- UART_CSn and ROM_CEn are independent of R_Wn.
- Never assert both DTACKn and VPAn; never assert BERRn together with either.
- Counter: 8 bits unsigned; it never wraps. It stops at 0 in WAIT, and the timeout counter saturates.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A separate 8-bit timeout counter clears on entry to WAIT and increments each edge while in WAIT.
  - When it reaches TIMEOUT_CYCLES in WAIT, go to BERR: BERRn=0 and no selects, held until ASn sampled 1, then IDLE.
  - Applies to UNMAPPED only, since mapped regions always acknowledge within 255 cycles.
- Not defined: no timeout logic is synthesized, BERRn is constant 1, and UNMAPPED cycles sit in WAIT until ASn rises or reset.

Test Plan:
- ROM read at 0x000004, ROM_WS=2, ASn low at edge 0 -> ROM_CEn=0 from edge 1, DTACKn=0 at edge 3. ASn high at edge 5 -> all outputs 1 at edge 5.
- SRAM byte write at 0x100010, R_Wn=0, UDSn=0, LDSn=1, SRAM_WS=0 -> SRAM_CEn=0, SRAM_WEn=0, SRAM_UBn=0, SRAM_LBn=1, SRAM_OEn=1, DTACKn=0 at edge 1.
- IACK, FC=3'b111, addr=0x7FFFF8 (byte 0xFFFFF0) -> VPAn=0 at edge 1, DTACKn stays 1, no chip select.
- Unmapped read at 0x800000 with BUS_TIMEOUT_EN, TIMEOUT_CYCLES=64 -> BERRn=0 after 64 WAIT edges, DTACKn stays 1. Without the macro, no acknowledge after 300 cycles.
- Abort and reset:
  - UART cycle, IO_WS=4, ASn raised at edge 2 -> IDLE at edge 2, DTACKn never 0.
  - Repeat with RESETn pulsed low mid-WAIT -> all outputs 1 immediately (asynchronously).
- Back-to-back: ASn held low through two ROM cycles without going high -> exactly one DTACKn assertion.
